lights_frame_writer: RTL and testbench

Upstream producer for the LED strip output stage. Each frame period it renders a GRB pattern (solid fill, single-LED chase, or clear) and writes it as packed 16-bit words into the LED frame buffer in shared memory. The output stage reads that buffer from BASE_ADR and serialises it. Memory access is through a req/ack master port matching the one the output stage uses.

---
 rtl/lights_frame_writer_if.sv | 12 +
 rtl/lights_frame_writer.sv | 168 ++++++++++++++++
 tb/tb_lights_frame_writer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lights_frame_writer_if.sv
// Word-wide req/ack memory port shared by the LED frame producer and the output stage.
interface lights_frame_writer_if;
  logic [17:0] adr;
  logic        req;
  logic        ack;
  logic        write;
  logic [1:0]  sel;
  logic [15:0] wdata;

  modport master (output adr, req, write, sel, wdata, input ack);
  modport slave  (input adr, req, write, sel, wdata, output ack);
endinterface

// File: rtl/lights_frame_writer.sv
// Renders one GRB frame (solid, chase or clear) per frame period into the packed LED buffer.
// state | meaning: IDLE wait for frame_start | WRITE present word, advance on ack | DONE pulse frame_done, step head
module lights_frame_writer #(
  parameter int BASE_ADR    = 500,
  parameter int NUM_LEDS    = 100,
  parameter int FRAME_TICKS = 500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [23:0]           colour,
  output logic                  busy,
  output logic                  frame_done,
  output logic [8:0]            head,
  lights_frame_writer_if.master m_b
);

  localparam int NUM_BYTES = 3 * NUM_LEDS;
  localparam int NUM_WORDS = (NUM_BYTES + 1) / 2;
  localparam int TW        = $clog2(FRAME_TICKS + 1);
  localparam int WW        = $clog2(NUM_WORDS + 1);
  localparam int LW        = 10;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t          state, state_d;
  logic [TW-1:0]   tick;
  logic            frame_start;
  logic [WW-1:0]   word_idx;
  logic [LW-1:0]   led_lo;
  logic [1:0]      chan_lo;
  logic [LW-1:0]   led_hi;
  logic [1:0]      chan_hi;
  logic            hi_valid;
  logic            last_word;
  logic [1:0]      mode_q;
  logic [23:0]     colour_q;

  function automatic logic [7:0] byte_val(input logic [1:0] md, input logic [23:0] col,
                                          input logic [LW-1:0] led, input logic [1:0] ch,
                                          input logic [8:0] hd);
    logic [7:0] c;
    case (ch)
      2'd0:    c = col[23:16];
      2'd1:    c = col[15:8];
      default: c = col[7:0];
    endcase
    case (md)
      2'd0:    return c;
      2'd1:    return (led == {1'b0, hd}) ? c : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= '0;
    end else if (tick == TW'(FRAME_TICKS - 1)) begin
      tick <= '0;
    end else begin
      tick <= tick + TW'(1);
    end
  end

  assign frame_start = (tick == TW'(FRAME_TICKS - 1)) && enable;

  // The high byte of a word is always the byte right after the low one.
  always_comb begin
    chan_hi = 2'd0;
    led_hi  = led_lo;
    if (chan_lo == 2'd2) begin
      chan_hi = 2'd0;
      led_hi  = led_lo + LW'(1);
    end else begin
      chan_hi = chan_lo + 2'd1;
      led_hi  = led_lo;
    end
  end

  assign hi_valid  = (led_hi < LW'(NUM_LEDS));
  assign last_word = (word_idx == WW'(NUM_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (frame_start) state_d = WRITE;
      WRITE:   if (m_b.ack && last_word) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_idx   <= '0;
      led_lo     <= '0;
      chan_lo    <= 2'd0;
      mode_q     <= 2'd0;
      colour_q   <= 24'h0;
      head       <= 9'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == DONE);
      case (state)
        IDLE: begin
          if (frame_start) begin
            mode_q   <= mode;
            colour_q <= colour;
            word_idx <= '0;
            led_lo   <= '0;
            chan_lo  <= 2'd0;
          end
        end
        WRITE: begin
          if (m_b.ack) begin
            word_idx <= word_idx + WW'(1);
            case (chan_lo)
              2'd0: begin
                chan_lo <= 2'd2;
              end
              2'd1: begin
                chan_lo <= 2'd0;
                led_lo  <= led_lo + LW'(1);
              end
              default: begin
                chan_lo <= 2'd1;
                led_lo  <= led_lo + LW'(1);
              end
            endcase
          end
        end
        DONE: begin
          if (mode_q == 2'd1) begin
            head <= (head == 9'(NUM_LEDS - 1)) ? 9'd0 : head + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus outputs are decoded from state so an async reset drops req at once.
  always_comb begin
    m_b.req   = 1'b0;
    m_b.adr   = 18'd0;
    m_b.wdata = 16'h0000;
    if (state == WRITE) begin
      m_b.req   = 1'b1;
      m_b.adr   = 18'(BASE_ADR) + 18'(word_idx);
      m_b.wdata = {hi_valid ? byte_val(mode_q, colour_q, led_hi, chan_hi, head) : 8'h00,
                   byte_val(mode_q, colour_q, led_lo, chan_lo, head)};
    end
  end

  assign m_b.write = 1'b1;
  assign m_b.sel   = 2'b11;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_lights_frame_writer.sv
// Randomized scoreboard bench for lights_frame_writer with a byte-level frame model.
module tb_lights_frame_writer;

  localparam int BASE = 500;
  localparam int NL   = 3;
  localparam int FT   = 50;
  localparam int NW   = (3 * NL + 1) / 2;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] colour;
  logic        busy;
  logic        frame_done;
  logic [8:0]  head;

  lights_frame_writer_if mem ();

  lights_frame_writer #(.BASE_ADR(BASE), .NUM_LEDS(NL), .FRAME_TICKS(FT)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .colour     (colour),
    .busy       (busy),
    .frame_done (frame_done),
    .head       (head),
    .m_b        (mem)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  logic [17:0] exp_adr_q[$];
  logic [15:0] exp_dat_q[$];
  logic [8:0]  exp_head_q[$];
  logic [15:0] exp_img [0:NW-1];
  logic [15:0] mem_arr [0:1023];
  int          max_delay = 0;
  int          m_cnt = 0;
  int          m_head = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endfunction

  // Frame model: lay out bytes G,R,B per LED, then pair them into little-endian words.
  function automatic void build_frame(input logic [1:0] md, input logic [23:0] col, input int hd);
    logic [7:0] b [0:2*NW-1];
    logic [7:0] c;
    for (int k = 0; k < 2 * NW; k++) begin
      b[k] = 8'h00;
      if (k < 3 * NL) begin
        case (k % 3)
          0:       c = col[23:16];
          1:       c = col[15:8];
          default: c = col[7:0];
        endcase
        if (md == 2'd0) b[k] = c;
        else if (md == 2'd1 && (k / 3) == hd) b[k] = c;
      end
    end
    for (int w = 0; w < NW; w++) begin
      exp_adr_q.push_back(18'(BASE + w));
      exp_dat_q.push_back({b[2*w+1], b[2*w]});
      exp_img[w] = {b[2*w+1], b[2*w]};
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cnt = 0;
      end else begin
        if (m_cnt == FT - 1 && enable) begin
          build_frame(mode, colour, m_head);
          if (mode == 2'd1) m_head = (m_head == NL - 1) ? 0 : m_head + 1;
          exp_head_q.push_back(9'(m_head));
        end
        m_cnt = (m_cnt == FT - 1) ? 0 : m_cnt + 1;
      end
    end
  end

  // Memory responder with random wait states and stray acks while idle.
  initial begin
    int wcnt;
    wcnt = -1;
    mem.ack = 1'b0;
    forever begin
      @(negedge clk);
      mem.ack = 1'b0;
      if (mem.req && !rst) begin
        if (wcnt < 0) wcnt = $urandom_range(max_delay, 0);
        if (wcnt == 0) begin
          mem.ack = 1'b1;
          wcnt = -1;
        end else begin
          wcnt--;
        end
      end else begin
        wcnt = -1;
        if ($urandom_range(3, 0) == 0) mem.ack = 1'b1;
      end
    end
  end

  initial begin
    logic        waiting;
    logic [17:0] hold_adr;
    logic [15:0] hold_dat;
    int          busy_len;
    waiting  = 1'b0;
    hold_adr = '0;
    hold_dat = '0;
    busy_len = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        waiting  = 1'b0;
        busy_len = 0;
      end else begin
        if (waiting) begin
          chk("hold_req", {31'd0, mem.req}, 32'd1);
          chk("hold_adr", {14'd0, mem.adr}, {14'd0, hold_adr});
          chk("hold_wdata", {16'd0, mem.wdata}, {16'd0, hold_dat});
          waiting = 1'b0;
        end
        if (mem.req && mem.ack) begin
          if (mem.adr < 18'd1024) mem_arr[mem.adr] = mem.wdata;
          if (exp_adr_q.size() == 0) begin
            fail_now("unexpected_write");
          end else begin
            chk("write_adr", {14'd0, mem.adr}, {14'd0, exp_adr_q.pop_front()});
            chk("write_data", {16'd0, mem.wdata}, {16'd0, exp_dat_q.pop_front()});
            chk("write_sel", {29'd0, mem.write, mem.sel}, 32'd7);
          end
        end else if (mem.req) begin
          waiting  = 1'b1;
          hold_adr = mem.adr;
          hold_dat = mem.wdata;
        end
        if (frame_done) begin
          if (exp_head_q.size() == 0) fail_now("unexpected_frame_done");
          else chk("head_after_frame", {23'd0, head}, {23'd0, exp_head_q.pop_front()});
        end
        if (busy) begin
          busy_len++;
        end else if (busy_len > 0) begin
          if (max_delay == 0) chk("busy_cycles", busy_len, NW + 1);
          busy_len = 0;
        end
      end
    end
  end

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit found;
    rst    = 1'b1;
    enable = 1'b0;
    mode   = 2'd0;
    colour = 24'h0;
    run_cycles(3);
    chk("rst_req", {31'd0, mem.req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_head", {23'd0, head}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_adr", {14'd0, mem.adr}, 32'd0);
    chk("rst_wdata", {16'd0, mem.wdata}, 32'd0);
    rst = 1'b0;

    // Solid fill with immediate ack.
    mode   = 2'd0;
    colour = 24'h112233;
    enable = 1'b1;
    run_cycles(2 * FT + 10);

    // Chase walks the head through every LED and wraps.
    mode   = 2'd1;
    colour = 24'hAABBCC;
    run_cycles(4 * FT);

    // Random wait states with mode/colour changing mid-frame.
    max_delay = 5;
    for (int f = 0; f < 16; f++) begin
      run_cycles($urandom_range(40, 10));
      mode   = 2'($urandom_range(3, 0));
      colour = 24'($urandom);
    end

    // Enable dropped mid-frame: that frame finishes, no new ones start.
    mode   = 2'd0;
    colour = 24'h405060;
    found  = 0;
    for (int i = 0; i < 3 * FT; i++) begin
      @(negedge clk);
      if (busy) begin
        found = 1;
        break;
      end
    end
    if (!found) fail_now("timeout_wait_busy");
    enable = 1'b0;
    run_cycles(3 * FT);
    chk("idle_after_disable", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    run_cycles(FT + 20);

    // Clear with all-ones colour must write zeros and never move head.
    mode   = 2'd2;
    colour = 24'hFFFFFF;
    run_cycles(3 * FT);

    // Asynchronous reset during the third word of a frame.
    max_delay = 2;
    mode      = 2'd0;
    colour    = 24'h0A0B0C;
    found     = 0;
    for (int i = 0; i < 4 * FT; i++) begin
      @(negedge clk);
      if (mem.req && mem.adr == 18'(BASE + 2)) begin
        found = 1;
        break;
      end
    end
    if (!found) fail_now("timeout_wait_word3");
    #1;
    rst = 1'b1;
    exp_adr_q.delete();
    exp_dat_q.delete();
    exp_head_q.delete();
    m_head = 0;
    #1;
    chk("midreset_req", {31'd0, mem.req}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_head", {23'd0, head}, 32'd0);
    run_cycles(3);
    rst = 1'b0;
    mode   = 2'd1;
    colour = 24'h123456;
    run_cycles(2 * FT + 10);
    mode   = 2'd0;
    colour = 24'h7E8E9E;
    run_cycles(FT);

    enable = 1'b0;
    run_cycles(2 * FT);
    chk("pending_writes", exp_adr_q.size(), 32'd0);
    chk("pending_frames", exp_head_q.size(), 32'd0);
    chk("final_busy", {31'd0, busy}, 32'd0);
    for (int w = 0; w < NW; w++) begin
      chk("buffer_image", {16'd0, mem_arr[BASE + w]}, {16'd0, exp_img[w]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
